// File: rtl/pipeline_pkg.sv
// Shared pipeline-control types and defaults used by the hazard logic.
// Holds the divide FSM state type and the load-use match helper.
package pipeline_pkg;

    localparam int DIV_LATENCY_DEFAULT = 8;
    localparam int REG_W               = 5;
    localparam int DIV_CNT_W           = 8;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    function automatic logic load_use_hit(
        input logic             is_load,
        input logic [REG_W-1:0] rd,
        input logic [REG_W-1:0] rs1,
        input logic [REG_W-1:0] rs2
    );
        return is_load && (rd != '0) && ((rd == rs1) || (rd == rs2));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: advances by one per enabled cycle and holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use and branch stalls/flushes plus a
// multi-cycle divide FSM that freezes the front end while the divider runs.
module hazard_unit
    import pipeline_pkg::*;
#(
    parameter int DIV_LATENCY = DIV_LATENCY_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] Rs1D,
    input  logic [REG_W-1:0] Rs2D,
    input  logic [REG_W-1:0] RdE,
    input  logic             ResultSrcE0,
    input  logic             PCSrcE,
    input  logic             DivStartE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             DivBusy,
    output logic             DivDone,
    output logic [REG_W-1:0] DivRd,
    output logic [31:0]      StallCycles
);

    localparam logic [DIV_CNT_W-1:0] CNT_LOAD = DIV_CNT_W'(DIV_LATENCY - 1);

    div_state_t           r_state;
    logic [DIV_CNT_W-1:0] r_cnt;
    logic [REG_W-1:0]     r_div_rd;
    logic                 w_load_use;

    assign w_load_use = load_use_hit(ResultSrcE0, RdE, Rs1D, Rs2D);

    // DONE deliberately ignores DivStartE: the divide is still sitting in
    // Execute for that cycle and must not be launched a second time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= DIV_IDLE;
            r_cnt    <= '0;
            r_div_rd <= '0;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    if (DivStartE) begin
                        r_state  <= DIV_BUSY;
                        r_cnt    <= CNT_LOAD;
                        r_div_rd <= RdE;
                    end
                end
                DIV_BUSY: begin
                    if (r_cnt == '0) begin
                        r_state <= DIV_DONE;
                    end else begin
                        r_cnt <= r_cnt - DIV_CNT_W'(1);
                    end
                end
                DIV_DONE: r_state <= DIV_IDLE;
                default:  r_state <= DIV_IDLE;
            endcase
        end
    end

    // A running divide overrides everything; otherwise a taken branch beats
    // a load-use stall, since the dependent instruction is being squashed.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushM = 1'b0;
        if (r_state == DIV_BUSY) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
        end else begin
            StallF = w_load_use && !PCSrcE;
            StallD = w_load_use && !PCSrcE;
            FlushD = PCSrcE;
            FlushE = w_load_use || PCSrcE;
        end
    end

    assign DivBusy = (r_state == DIV_BUSY);
    assign DivDone = (r_state == DIV_DONE);
    assign DivRd   = r_div_rd;

    sat_counter #(
        .WIDTH(32)
    ) u_stall_cnt (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_en   (StallF),
        .o_count(StallCycles)
    );

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 The block SHALL have parameter DIV_LATENCY, default 8, meaning total stall cycles per divide, legal range 1..255.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on the rising edge.
REQ-003 The block SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 The block SHALL have ports Rs1D and Rs2D, input, 5 each, the source registers of the instruction in Decode.
REQ-005 The block SHALL have port RdE, input, 5, the destination register of the instruction in Execute.
REQ-006 The block SHALL have port ResultSrcE0, input, 1; it is 1 when the Execute instruction is a load.
REQ-007 The block SHALL have port PCSrcE, input, 1; it is 1 when a branch or jump is taken in Execute.
REQ-008 The block SHALL have port DivStartE, input, 1; it is 1 while a divide instruction occupies Execute.
REQ-009 The block SHALL have ports StallF, StallD, StallE, output, 1 each, which hold the F, D and E pipeline registers.
REQ-010 The block SHALL have ports FlushD, FlushE, FlushM, output, 1 each, which clear the D, E and M pipeline registers to a bubble.
REQ-011 The block SHALL have port DivBusy, output, 1; it is 1 while the divide FSM is in BUSY.
REQ-012 The block SHALL have port DivDone, output, 1; it pulses for one cycle when the divide result may advance.
REQ-013 The block SHALL have port StallCycles, output, 32, a count of cycles with StallF=1.

Function
REQ-014 Load-use: when ResultSrcE0=1, RdE!=0 and (RdE==Rs1D or RdE==Rs2D), the block SHALL assert StallF=1, StallD=1 and FlushE=1.
REQ-015 Control hazard: PCSrcE=1 SHALL assert FlushD=1 and FlushE=1 in the same cycle.
REQ-016 When a load-use hazard and PCSrcE=1 occur together, FlushE SHALL be 1, and StallF and StallD SHALL be 0 because the branch wins.
REQ-017 The divide FSM SHALL have states IDLE, BUSY and DONE; the reset state is IDLE.
REQ-018 IDLE: if DivStartE=1, the FSM SHALL go to BUSY, load cnt=DIV_LATENCY-1 and latch RdE into DivRd.
REQ-019 BUSY: the block SHALL drive StallF=StallD=StallE=1 and FlushM=1, and force FlushD=FlushE=0; cnt SHALL decrement each cycle; at cnt==0 the FSM SHALL go to DONE.
REQ-020 DONE: the block SHALL assert DivDone=1 for exactly one cycle with no divide stall, ignore DivStartE so the same divide is not restarted, and return to IDLE.
REQ-021 Stall length per divide SHALL equal DIV_LATENCY cycles; with DIV_LATENCY=1 the FSM SHALL spend one cycle in BUSY.
REQ-022 In BUSY, the load-use and branch rules SHALL be suppressed; in IDLE and DONE they SHALL apply normally.
REQ-023 StallCycles SHALL increment on every cycle with StallF=1 and saturate at 32'hFFFF_FFFF with no wrap.
REQ-024 All stall and flush outputs SHALL be combinational from the inputs and the FSM state, with zero latency.

Reset
REQ-025 Asserting rst SHALL immediately force state=IDLE, cnt=0, DivRd=0 and StallCycles=0.
REQ-026 During reset, DivBusy=0 and DivDone=0, and stall/flush outputs SHALL depend only on the combinational hazard rules.
REQ-027 Reset asserted mid-BUSY SHALL abort the divide; no DivDone pulse SHALL follow.

Structure
REQ-028 The divide state enum type div_state_t and the DIV_LATENCY default SHALL live in the shared pipeline_pkg.
REQ-029 The saturating stall counter SHALL be the sub-module sat_counter (width 32, enable, async active-high reset); the FSM SHALL be inline.

Verification
REQ-030 Load-use: ResultSrcE0=1, RdE=5, Rs1D=5 -> StallF=StallD=FlushE=1 for one cycle, and StallCycles increments by 1.
REQ-031 x0 case: ResultSrcE0=1, RdE=0, Rs2D=0 -> no stall and no flush.
REQ-032 Divide: DivStartE=1 held, DIV_LATENCY=8 -> DivBusy=1 and stalls high for 8 cycles, then DivDone=1 for one cycle, then IDLE.
REQ-033 Combined hazards: PCSrcE=1 with a load-use match -> FlushD=FlushE=1 and StallF=0.
REQ-034 Reset mid-divide: rst pulse at BUSY cycle 3 -> state IDLE, DivBusy=0, StallCycles=0, and no DivDone follows.
REQ-035 Saturation: preload StallCycles near max, apply 3 stall cycles -> StallCycles holds at 32'hFFFF_FFFF.
